// File: rtl/uart_pkg.sv
// Shared definitions for the UART word serializer: byte width, FSM encoding
// and the word-to-byte count helper.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;

  function automatic int nbytes(input int width);
    return width / UART_BYTE_W;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Word FIFO with registered read data; FIFO_DEPTH must be a power of two so
// the pointers wrap naturally.
module uart_word_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst,
  input  logic                          i_Push,
  input  logic [DATA_WIDTH-1:0]         i_Push_Data,
  input  logic                          i_Pop,
  output logic [DATA_WIDTH-1:0]         o_Pop_Data,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign o_Full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign o_Empty    = (count_q == '0);
  assign o_Count    = count_q;
  assign o_Pop_Data = rd_data_q;

  // A push into a full FIFO is only taken when a pop frees the slot that cycle.
  assign push_ok = i_Push && (!o_Full || i_Pop);
  assign pop_ok  = i_Pop && !o_Empty;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_Push_Data;
    if (pop_ok)  rd_data_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_Clock or negedge i_Rst) begin
    if (!i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_word_serializer.sv
// Buffers words and feeds them MSB byte first to the UART transmitter.
// Define UART_TX_CHECKSUM_EN to append an XOR checksum byte to every word.
module uart_tx_word_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst,
  input  logic                        i_Word_Valid,
  input  logic [DATA_WIDTH-1:0]       i_Word,
  output logic                        o_Word_Ready,
  output logic                        o_TX_Valid,
  output logic [UART_BYTE_W-1:0]      o_TX_Byte,
  input  logic                        i_TX_Active,
  input  logic                        i_TX_Done,
  output logic                        o_Busy,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

  localparam int NBYTES = nbytes(DATA_WIDTH);
`ifdef UART_TX_CHECKSUM_EN
  localparam int LAST_IDX = NBYTES;
`else
  localparam int LAST_IDX = NBYTES - 1;
`endif
  localparam int IDX_W = $clog2(NBYTES + 1) + 1;

  logic [2:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
`ifdef UART_TX_CHECKSUM_EN
  logic [UART_BYTE_W-1:0] csum_q, csum_d;
`endif

  logic                   fifo_push, fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_data;
  logic [UART_BYTE_W-1:0] tx_byte;

  assign fifo_push = i_Word_Valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && !i_TX_Active;
  assign tx_byte   = shift_q[DATA_WIDTH-1 -: UART_BYTE_W];

  uart_word_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock     (i_Clock),
    .i_Rst       (i_Rst),
    .i_Push      (fifo_push),
    .i_Push_Data (i_Word),
    .i_Pop       (fifo_pop),
    .o_Pop_Data  (fifo_data),
    .o_Full      (fifo_full),
    .o_Empty     (fifo_empty),
    .o_Count     (o_Fifo_Count)
  );

  always_ff @(posedge i_Clock or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
`ifdef UART_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
`ifdef UART_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = fifo_data;
        idx_d   = '0;
`ifdef UART_TX_CHECKSUM_EN
        csum_d  = '0;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_TX_Done) begin
          shift_d = shift_q << UART_BYTE_W;
`ifdef UART_TX_CHECKSUM_EN
          csum_d = csum_q ^ tx_byte;
          // After the last data byte the checksum takes the MSB slot.
          if (idx_q == IDX_W'(NBYTES - 1)) begin
            shift_d = '0;
            shift_d[DATA_WIDTH-1 -: UART_BYTE_W] = csum_q ^ tx_byte;
          end
`endif
          if (idx_q < IDX_W'(LAST_IDX)) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_TX_Valid   = (state_q == ST_SEND);
    o_TX_Byte    = tx_byte;
    o_Busy       = !fifo_empty || (state_q != ST_IDLE);
    o_Word_Ready = !fifo_full;
  end

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Randomized scoreboard bench: a transmitter model consumes bytes and checks
// them against bytes derived from each accepted word.
module tb_uart_tx_word_serializer;

  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int NB     = DW / 8;
  localparam int CW     = $clog2(DEPTH) + 1;
`ifdef UART_TX_CHECKSUM_EN
  localparam int FRAMES = NB + 1;
`else
  localparam int FRAMES = NB;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          word_valid;
  logic [DW-1:0] word;
  logic          word_ready;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic          busy;
  logic [CW-1:0] fifo_count;

  logic model_active = 1'b0, hold_active = 1'b0;
  logic model_done = 1'b0, spur_done = 1'b0;
  assign tx_active = model_active | hold_active;
  assign tx_done   = model_done | spur_done;

  uart_tx_word_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock      (clk),
    .i_Rst        (rst_n),
    .i_Word_Valid (word_valid),
    .i_Word       (word),
    .o_Word_Ready (word_ready),
    .o_TX_Valid   (tx_valid),
    .o_TX_Byte    (tx_byte),
    .i_TX_Active  (tx_active),
    .i_TX_Done    (tx_done),
    .o_Busy       (busy),
    .o_Fifo_Count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  bit   model_busy = 0;
  int   model_cnt = 0;
  logic [7:0] cur_byte = '0;
  int   tx_frame = 10;
  int   valid_count = 0;
  int   done_count = 0;
  int   first_valid_cyc = -1;
  int   double_done_at = -1;
  bit   extra_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bytes of a word MSB first, plus an XOR byte when enabled.
  task automatic ref_push(input logic [DW-1:0] w);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    for (int i = 0; i < NB; i++) begin
      b = w[8*(NB-1-i) +: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef UART_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Transmitter model and scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_busy = 0; model_active = 1'b0; model_done = 1'b0; extra_done = 0;
        continue;
      end
      model_done = extra_done;
      extra_done = 0;
      if (tx_valid) begin
        check("valid_while_active", {63'd0, tx_active}, 64'd0);
        valid_count++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_byte: got %0h, expected none (cycle %0d)", tx_byte, cyc);
        end else begin
          check("tx_byte", {56'd0, tx_byte}, {56'd0, exp_q.pop_front()});
        end
        cur_byte = tx_byte; model_busy = 1; model_cnt = tx_frame; model_active = 1'b1;
      end else if (model_busy) begin
        if (tx_byte !== cur_byte) check("byte_stable", {56'd0, tx_byte}, {56'd0, cur_byte});
        model_cnt--;
        if (model_cnt == 0) begin
          model_busy = 0; model_active = 1'b0; model_done = 1'b1;
          done_count++;
          if (done_count == double_done_at) extra_done = 1;
        end
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w, output int acc_cyc);
    int k;
    word_valid = 1'b1; word = w; k = 0;
    while (!word_ready && k < 2000) begin @(negedge clk); k++; end
    if (!word_ready) begin
      check("push_timeout", 64'd1, 64'd0);
      word_valid = 1'b0; acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    ref_push(w);
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || model_busy || busy) && k < 5000) begin @(negedge clk); k++; end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_byte", {56'd0, tx_byte}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_count", {{(64-CW){1'b0}}, fifo_count}, 64'd0);
    check("rst_ready", {63'd0, word_ready}, 64'd1);
  endtask

  initial begin
    int acc, v0, d0, k, rel;
    logic [DW-1:0] w;
    rst_n = 1'b0; word_valid = 1'b0; word = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Single word: order, latency and busy release.
    tx_frame = 10; v0 = valid_count; d0 = done_count; first_valid_cyc = -1;
    push_word(32'hA1B2C3D4, acc);
    k = 0;
    while (done_count < d0 + FRAMES && k < 2000) begin @(negedge clk); #1; k++; end
    check("t1_busy_at_last_done", {63'd0, busy}, 64'd1);
    @(negedge clk); #1;
    check("t1_busy_after", {63'd0, busy}, 64'd0);
    check("t1_latency", first_valid_cyc - acc, 2);
    check("t1_pulses", valid_count - v0, FRAMES);

    // FIFO fill while the transmitter is held busy.
    hold_active = 1'b1; v0 = valid_count;
    for (int i = 0; i < DEPTH; i++) push_word($urandom, acc);
    check("t2_count_full", {{(64-CW){1'b0}}, fifo_count}, DEPTH);
    check("t2_ready_low", {63'd0, word_ready}, 64'd0);
    word_valid = 1'b1; word = $urandom;
    repeat (5) @(negedge clk);
    check("t2_still_full", {{(64-CW){1'b0}}, fifo_count}, DEPTH);
    check("t2_no_valid", valid_count - v0, 0);
    rel = cyc; hold_active = 1'b0;
    push_word(word, acc);
    check("t2_fifth_after_pop", {63'd0, acc > rel + 1}, 64'd1);
    drain();
    check("t2_pulses", valid_count - v0, 5 * FRAMES);

    // Active held high when a word arrives.
    hold_active = 1'b1; v0 = valid_count;
    push_word($urandom, acc);
    repeat (20) @(negedge clk);
    check("t3_no_valid", valid_count - v0, 0);
    check("t3_busy", {63'd0, busy}, 64'd1);
    hold_active = 1'b0;
    drain();
    check("t3_pulses", valid_count - v0, FRAMES);

    // Spurious done in IDLE, doubled done on byte 2.
    v0 = valid_count;
    spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_idle_done_ignored", valid_count - v0, 0);
    check("t4_idle_busy", {63'd0, busy}, 64'd0);
    double_done_at = done_count + 2;
    push_word($urandom, acc);
    drain();
    double_done_at = -1;
    check("t4_pulses", valid_count - v0, FRAMES);

    // Reset after the first byte discards the word and queued data.
    v0 = valid_count;
    push_word(32'h11223344, acc);
    push_word(32'hDEADBEEF, acc);
    k = 0;
    while (valid_count < v0 + 1 && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_no_valid_after_reset", valid_count - v0, 1);
    v0 = valid_count;
    push_word(32'h55667788, acc);
    drain();
    check("t5_pulses", valid_count - v0, FRAMES);

    // Frame length (checksum byte only when enabled).
    v0 = valid_count;
    push_word(32'h01020304, acc);
    drain();
    check("t6_pulses", valid_count - v0, FRAMES);

    // Randomized words, frame lengths and gaps.
    v0 = valid_count;
    for (int i = 0; i < 20; i++) begin
      tx_frame = $urandom_range(3, 14);
      w = $urandom;
      push_word(w, acc);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();
    check("rand_pulses", valid_count - v0, 20 * FRAMES);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
